// File: rtl/ttt_pkg.sv
// ttt_pkg: shared cell encoding, game_state codes and winning-line masks
package ttt_pkg;
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_HUMAN = 2'b01;
    localparam logic [1:0] CELL_CPU   = 2'b10;

    localparam logic [2:0] GS_SELECT = 3'd0;
    localparam logic [2:0] GS_PLAY   = 3'd1;
    localparam logic [2:0] GS_WIN    = 3'd2;
    localparam logic [2:0] GS_LOSE   = 3'd3;
    localparam logic [2:0] GS_DRAW   = 3'd4;

    // Cell masks per line: rows 0-2, columns 3-5, diagonal 6, anti-diagonal 7
    localparam logic [8:0] LINE_MASK [8] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };
endpackage

// File: rtl/ttt_line_judge.sv
// ttt_line_judge: combinational line/full detector for a 3x3 board
module ttt_line_judge
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    output logic        human_win,
    output logic        cpu_win,
    output logic [7:0]  win_line,
    output logic        full
);
    logic [8:0] h;
    logic [8:0] c;
    logic [7:0] hl;
    logic [7:0] cl;

    // Split the board into per-player occupancy and test every line mask
    always_comb begin
        h  = '0;
        c  = '0;
        hl = '0;
        cl = '0;
        for (int i = 0; i < 9; i++) begin
            h[i] = board[2*i +: 2] == CELL_HUMAN;
            c[i] = board[2*i +: 2] == CELL_CPU;
        end
        for (int l = 0; l < 8; l++) begin
            hl[l] = (h & LINE_MASK[l]) == LINE_MASK[l];
            cl[l] = (c & LINE_MASK[l]) == LINE_MASK[l];
        end
        human_win = |hl;
        cpu_win   = |cl;
        win_line  = hl | cl;
        full      = &(h | c);
    end
endmodule

// File: rtl/ttt_turn_controller.sv
// ttt_turn_controller: board owner and turn sequencer; TTT_CPU_TIMEOUT_EN enables CPU move fallback
module ttt_turn_controller
    import ttt_pkg::*;
#(
    parameter int CPU_TIMEOUT = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [8:0]  board_but,
    input  logic        cpu_ack,
    input  logic [3:0]  cpu_move,
    output logic        cpu_req,
    output logic [17:0] board,
    output logic [2:0]  game_state,
    output logic        player_turn,
    output logic [3:0]  move_count,
    output logic [7:0]  win_line,
    output logic        cpu_err
);
    localparam logic [2:0] ST_SELECT   = 3'd0;
    localparam logic [2:0] ST_HUMAN    = 3'd1;
    localparam logic [2:0] ST_CPU_WAIT = 3'd2;
    localparam logic [2:0] ST_APPLY    = 3'd3;
    localparam logic [2:0] ST_JUDGE    = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    logic [8:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [3:0]  rnd_q, rnd_d, mv_q, mv_d, mc_q, mc_d;
    logic [2:0]  st_q, st_d, gs_q, gs_d;
    logic [17:0] board_q, board_d;
    logic [7:0]  wl_q, wl_d;
    logic        turn_q, turn_d, err_q, err_d;
    logic [8:0]  pulse, occ9;
    logic [15:0] occ;
    logic        cpu_ok, hfound;
    logic [3:0]  hpick;
    logic        human_win, cpu_win, full;
    logic [7:0]  judge_line;
`ifdef TTT_CPU_TIMEOUT_EN
    localparam int TW = CPU_TIMEOUT > 1 ? $clog2(CPU_TIMEOUT) : 1;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    fb_cell;
    int            j;
`endif

    ttt_line_judge u_judge (
        .board     (board_q),
        .human_win (human_win),
        .cpu_win   (cpu_win),
        .win_line  (judge_line),
        .full      (full)
    );

    // Press edges, cell occupancy, move validity and the human cell pick
    always_comb begin
        pulse  = s3_q & ~s2_q;
        occ9   = '0;
        hfound = 1'b0;
        hpick  = '0;
        for (int i = 0; i < 9; i++) occ9[i] = |board_q[2*i +: 2];
        occ    = {7'h7f, occ9};
        cpu_ok = !occ[cpu_move];
        for (int i = 8; i >= 0; i--) begin
            if (pulse[i] && !occ9[i]) begin
                hfound = 1'b1;
                hpick  = 4'(i);
            end
        end
`ifdef TTT_CPU_TIMEOUT_EN
        fb_cell = '0;
        j       = 0;
        for (int k = 8; k >= 0; k--) begin
            j = (int'(rnd_q) + k) % 9;
            if (!occ9[j]) fb_cell = 4'(j);
        end
`endif
    end

    // Game FSM: selection, move capture, board write, judging and end of game
    always_comb begin
        s1_d    = board_but;
        s2_d    = s1_q;
        s3_d    = s2_q;
        rnd_d   = rnd_q == 4'd8 ? 4'd0 : rnd_q + 4'd1;
        st_d    = st_q;
        gs_d    = gs_q;
        board_d = board_q;
        wl_d    = wl_q;
        turn_d  = turn_q;
        mc_d    = mc_q;
        mv_d    = mv_q;
        err_d   = 1'b0;
`ifdef TTT_CPU_TIMEOUT_EN
        tmo_d   = '0;
`endif
        case (st_q)
            ST_SELECT: if (pulse[0] || pulse[2]) begin
                board_d = '0;
                gs_d    = GS_PLAY;
                turn_d  = !pulse[0];
                st_d    = pulse[0] ? ST_HUMAN : ST_CPU_WAIT;
            end
            ST_HUMAN: if (hfound) begin
                mv_d = hpick;
                st_d = ST_APPLY;
            end
            ST_CPU_WAIT: begin
                err_d = cpu_ack && !cpu_ok;
                if (cpu_ack && cpu_ok) begin
                    mv_d = cpu_move;
                    st_d = ST_APPLY;
                end
`ifdef TTT_CPU_TIMEOUT_EN
                else if (tmo_q == TW'(CPU_TIMEOUT - 1)) begin
                    mv_d = fb_cell;
                    st_d = ST_APPLY;
                end else tmo_d = tmo_q + 1'b1;
`endif
            end
            ST_APPLY: begin
                for (int i = 0; i < 9; i++)
                    if (mv_q == 4'(i)) board_d[2*i +: 2] = turn_q ? CELL_CPU : CELL_HUMAN;
                mc_d   = mc_q + 4'd1;
                turn_d = !turn_q;
                st_d   = ST_JUDGE;
            end
            ST_JUDGE: begin
                if (human_win || cpu_win) begin
                    st_d = ST_DONE;
                    wl_d = judge_line;
                    gs_d = human_win ? GS_WIN : GS_LOSE;
                end else if (full) begin
                    st_d = ST_DONE;
                    gs_d = GS_DRAW;
                end else st_d = turn_q ? ST_CPU_WAIT : ST_HUMAN;
            end
            ST_DONE: if (|pulse) begin
                st_d   = ST_SELECT;
                gs_d   = GS_SELECT;
                wl_d   = '0;
                mc_d   = '0;
                turn_d = 1'b0;
            end
            default: st_d = ST_SELECT;
        endcase
    end

    // State registers; button synchronisers reset to the released level
    always_ff @(posedge CLK) begin
        if (!RST) begin
            s1_q    <= '1;
            s2_q    <= '1;
            s3_q    <= '1;
            rnd_q   <= '0;
            st_q    <= ST_SELECT;
            gs_q    <= GS_SELECT;
            board_q <= '0;
            wl_q    <= '0;
            turn_q  <= 1'b0;
            mc_q    <= '0;
            mv_q    <= '0;
            err_q   <= 1'b0;
`ifdef TTT_CPU_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
            gs_q    <= gs_d;
            board_q <= board_d;
            wl_q    <= wl_d;
            turn_q  <= turn_d;
            mc_q    <= mc_d;
            mv_q    <= mv_d;
            err_q   <= err_d;
`ifdef TTT_CPU_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign cpu_req     = st_q == ST_CPU_WAIT;
    assign board       = board_q;
    assign game_state  = gs_q;
    assign player_turn = turn_q;
    assign move_count  = mc_q;
    assign win_line    = wl_q;
    assign cpu_err     = err_q;
endmodule
